// File: rtl/alu_out_mux_pipe.sv
// alu_out_mux_pipe: registered one-hot result mux for the ALU output stage.
//
// Picks one of N K-bit channel results with a one-hot select and tags the
// result with a zero flag and a select-error flag. The tagged entry is queued
// in a DEPTH-entry buffer with valid/ready on both sides. Every accepted entry
// with an illegal select is also tracked by a sticky flag and a saturating
// counter.
//
// Ports:
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   in_data       packed channel results, channel i at [i*K +: K]
//   sel           one-hot channel select
//   in_valid      producer has an entry
//   in_ready      buffer has room (occupancy < DEPTH)
//   out_data      head entry result (last value held while empty)
//   out_zero      head entry result is zero
//   out_sel_err   head entry had an illegal select
//   out_valid     buffer non-empty
//   out_ready     consumer takes the head entry
//   err_clr       synchronous clear of err_sticky / err_count
//   err_sticky    an illegal select was accepted since reset or clear
//   err_count     saturating count of accepted illegal selects
module alu_out_mux_pipe #(
  parameter int unsigned K     = 7,
  parameter int unsigned N     = 6,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N*K-1:0]   in_data,
  input  logic [N-1:0]     sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [K-1:0]     out_data,
  output logic             out_zero,
  output logic             out_sel_err,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             err_clr,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OccW = $clog2(DEPTH + 1);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [OccW-1:0] occ_t;

  localparam ptr_t             LastPtr = ptr_t'(DEPTH - 1);
  localparam occ_t             Full    = occ_t'(DEPTH);
  localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

  // ---------------------------------------------------------------------------
  // Select decode and result tagging
  // ---------------------------------------------------------------------------
  logic         sel_legal;
  logic [K-1:0] mux_result;
  logic [K-1:0] wr_data;
  logic         wr_zero;
  logic         wr_err;

  always_comb begin
    // Exactly one bit set: non-zero and clearing the lowest set bit leaves 0.
    sel_legal  = (sel != '0) && ((sel & (sel - N'(1))) == '0);
    mux_result = '0;
    for (int i = 0; i < N; i++) begin
      mux_result = mux_result | (in_data[i*K +: K] & {K{sel[i]}});
    end
    wr_data = sel_legal ? mux_result : '0;
    wr_zero = (wr_data == '0);
    wr_err  = ~sel_legal;
  end

  // ---------------------------------------------------------------------------
  // Output buffer
  // ---------------------------------------------------------------------------
  logic [K-1:0]     mem_data_q [DEPTH];
  logic [K-1:0]     mem_data_d [DEPTH];
  logic [DEPTH-1:0] mem_zero_q, mem_zero_d;
  logic [DEPTH-1:0] mem_err_q,  mem_err_d;
  ptr_t             wr_ptr_q, wr_ptr_d;
  ptr_t             rd_ptr_q, rd_ptr_d;
  occ_t             occ_q, occ_d;

  // Copy of the most recently popped entry, shown while the buffer is empty.
  logic [K-1:0]     last_data_q, last_data_d;
  logic             last_zero_q, last_zero_d;
  logic             last_err_q,  last_err_d;

  logic             push;
  logic             pop;
  logic [K-1:0]     head_data;
  logic             head_zero;
  logic             head_err;

  // in_ready depends on registered occupancy only, so a pop while full
  // cannot make room in the same cycle.
  assign in_ready  = (occ_q < Full);
  assign out_valid = (occ_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign head_data = mem_data_q[rd_ptr_q];
  assign head_zero = mem_zero_q[rd_ptr_q];
  assign head_err  = mem_err_q[rd_ptr_q];

  assign out_data    = out_valid ? head_data : last_data_q;
  assign out_zero    = out_valid ? head_zero : last_zero_q;
  assign out_sel_err = out_valid ? head_err  : last_err_q;

  always_comb begin
    mem_data_d = mem_data_q;
    mem_zero_d = mem_zero_q;
    mem_err_d  = mem_err_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    last_data_d = last_data_q;
    last_zero_d = last_zero_q;
    last_err_d  = last_err_q;

    if (push) begin
      mem_data_d[wr_ptr_q] = wr_data;
      mem_zero_d[wr_ptr_q] = wr_zero;
      mem_err_d[wr_ptr_q]  = wr_err;
      wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + ptr_t'(1);
    end

    if (pop) begin
      last_data_d = head_data;
      last_zero_d = head_zero;
      last_err_d  = head_err;
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + ptr_t'(1);
    end

    unique case ({push, pop})
      2'b10:   occ_d = occ_q + occ_t'(1);
      2'b01:   occ_d = occ_q - occ_t'(1);
      default: occ_d = occ_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Error tracking (accepted entries only)
  // ---------------------------------------------------------------------------
  logic             err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0] err_count_q,  err_count_d;
  logic             err_accept;

  assign err_accept = push & wr_err;

  always_comb begin
    err_sticky_d = err_sticky_q;
    err_count_d  = err_count_q;
    if (err_clr) begin
      // A clear coinciding with an illegal accept leaves that one counted.
      err_sticky_d = err_accept;
      err_count_d  = err_accept ? CNT_W'(1) : '0;
    end else if (err_accept) begin
      err_sticky_d = 1'b1;
      if (err_count_q != CntMax) begin
        err_count_d = err_count_q + CNT_W'(1);
      end
    end
  end

  assign err_sticky = err_sticky_q;
  assign err_count  = err_count_q;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data_q[i] <= '0;
      end
      mem_zero_q   <= '0;
      mem_err_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      last_data_q  <= '0;
      last_zero_q  <= 1'b0;
      last_err_q   <= 1'b0;
      err_sticky_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      mem_data_q   <= mem_data_d;
      mem_zero_q   <= mem_zero_d;
      mem_err_q    <= mem_err_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      last_data_q  <= last_data_d;
      last_zero_q  <= last_zero_d;
      last_err_q   <= last_err_d;
      err_sticky_q <= err_sticky_d;
      err_count_q  <= err_count_d;
    end
  end

endmodule
